// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator crossing detector slice.
//   - cmp_state_t : tracked-state encoding (INIT / BELOW / ABOVE)
//   - cmp_kind_t  : decoded meaning of one {greater, equal, smaller} sample
//   - CMP_GT / CMP_EQ / CMP_LT : the legal one-hot comparator triplets,
//     ordered {greater, equal, smaller}
// ---------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_ST_INIT  = 2'd0,
    CMP_ST_BELOW = 2'd1,
    CMP_ST_ABOVE = 2'd2
  } cmp_state_t;

  // CMP_K_BAD is only produced when one-hot checking is compiled in.
  typedef enum logic [1:0] {
    CMP_K_EQ  = 2'd0,
    CMP_K_GT  = 2'd1,
    CMP_K_LT  = 2'd2,
    CMP_K_BAD = 2'd3
  } cmp_kind_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/cmp_evt_counter.sv
// ---------------------------------------------------------------------------
// cmp_evt_counter
// Wrapping event counter with a synchronous clear that beats increment.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   inc    - count one event on this edge
//   clear  - zero the counter on this edge (wins over inc)
//   count  - current count, wraps from all-ones to zero
// ---------------------------------------------------------------------------
module cmp_evt_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Clear has priority so an event coinciding with clear leaves the count at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cmp_crossing_detector.sv
// ---------------------------------------------------------------------------
// cmp_crossing_detector
// Tracks whether a compared value sits above or below its reference, using
// the {greater, equal, smaller} triplet of a magnitude comparator. A state
// change needs PERSIST consecutive qualifying samples; EQ samples hold the
// run (hysteresis band) and in_valid=0 cycles are transparent.
//
// Optional feature macro: CMP_ONEHOT_CHECK_EN
//   defined   - non-one-hot valid triplets are ignored and set sticky err
//   undefined - priority decode greater > smaller > equal, 000 = EQ, err = 0
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid             - triplet is sampled this cycle
//   greater/equal/smaller- comparator result
//   clear                - zero both event counters and err
//   state_above          - tracked state is ABOVE
//   state_known          - tracked state has left INIT
//   rise_pulse/fall_pulse- one-cycle crossing events
//   rise_count/fall_count- wrapping event counters
//   run_len              - current qualifying run length
//   err                  - sticky triplet error flag
// ---------------------------------------------------------------------------
module cmp_crossing_detector
  import cmp_pkg::*;
#(
  parameter int PERSIST       = 3,
  parameter int PERSIST_W     = 8,
  parameter int EVT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     greater,
  input  logic                     equal,
  input  logic                     smaller,
  input  logic                     clear,
  output logic                     state_above,
  output logic                     state_known,
  output logic                     rise_pulse,
  output logic                     fall_pulse,
  output logic [EVT_CNT_WIDTH-1:0] rise_count,
  output logic [EVT_CNT_WIDTH-1:0] fall_count,
  output logic [PERSIST_W-1:0]     run_len,
  output logic                     err
);

  cmp_state_t           state;
  cmp_kind_t            kind;
  logic [2:0]           trip;
  logic [PERSIST_W-1:0] run_inc;
  logic                 run_hit;
  logic                 rise_evt;
  logic                 fall_evt;

  assign trip = {greater, equal, smaller};

  // Decode the sample and detect the edge on which a run completes. The
  // event strobes feed both the pulse registers and the counters so that
  // the pulse and the updated count appear on the same cycle.
  always_comb begin
    kind = CMP_K_EQ;
`ifdef CMP_ONEHOT_CHECK_EN
    case (trip)
      CMP_GT:  kind = CMP_K_GT;
      CMP_LT:  kind = CMP_K_LT;
      CMP_EQ:  kind = CMP_K_EQ;
      default: kind = CMP_K_BAD;
    endcase
`else
    casez (trip)
      3'b1??:  kind = CMP_K_GT;
      3'b0?1:  kind = CMP_K_LT;
      default: kind = CMP_K_EQ;
    endcase
`endif
    run_inc  = run_len + PERSIST_W'(1);
    run_hit  = (run_inc == PERSIST_W'(PERSIST));
    rise_evt = in_valid && (state == CMP_ST_BELOW) && (kind == CMP_K_GT) && run_hit;
    fall_evt = in_valid && (state == CMP_ST_ABOVE) && (kind == CMP_K_LT) && run_hit;
  end

  // Tracking FSM. The first decisive sample out of INIT only establishes the
  // state; it is not a crossing, so it produces no pulse. An opposite-side
  // sample resets the run, EQ (and a rejected triplet) leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CMP_ST_INIT;
      run_len     <= '0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      state_above <= 1'b0;
      state_known <= 1'b0;
    end else begin
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
      if (in_valid) begin
        case (state)
          CMP_ST_INIT: begin
            if (kind == CMP_K_GT) begin
              state       <= CMP_ST_ABOVE;
              state_above <= 1'b1;
              state_known <= 1'b1;
            end else if (kind == CMP_K_LT) begin
              state       <= CMP_ST_BELOW;
              state_above <= 1'b0;
              state_known <= 1'b1;
            end
          end
          CMP_ST_BELOW: begin
            if (kind == CMP_K_GT) begin
              if (run_hit) begin
                state       <= CMP_ST_ABOVE;
                state_above <= 1'b1;
                run_len     <= '0;
              end else begin
                run_len <= run_inc;
              end
            end else if (kind == CMP_K_LT) begin
              run_len <= '0;
            end
          end
          CMP_ST_ABOVE: begin
            if (kind == CMP_K_LT) begin
              if (run_hit) begin
                state       <= CMP_ST_BELOW;
                state_above <= 1'b0;
                run_len     <= '0;
              end else begin
                run_len <= run_inc;
              end
            end else if (kind == CMP_K_GT) begin
              run_len <= '0;
            end
          end
          default: begin
            state       <= CMP_ST_INIT;
            run_len     <= '0;
            state_above <= 1'b0;
            state_known <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  // Sticky error on any rejected triplet; clear wins if both happen together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (in_valid && (kind == CMP_K_BAD)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  cmp_evt_counter #(.WIDTH(EVT_CNT_WIDTH)) u_rise_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rise_evt),
    .clear (clear),
    .count (rise_count)
  );

  cmp_evt_counter #(.WIDTH(EVT_CNT_WIDTH)) u_fall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fall_evt),
    .clear (clear),
    .count (fall_count)
  );

endmodule

// File: tb/tb_cmp_crossing_detector.sv
// ---------------------------------------------------------------------------
// tb_cmp_crossing_detector
// Directed plus short random stimulus for cmp_crossing_detector. Each driven
// cycle updates a behavioural model, pushes the expected outputs onto a
// scoreboard queue, and the entry is popped and compared after the edge.
// Counters are built 4 bits wide here so wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_cmp_crossing_detector;

  localparam int PERSIST   = 3;
  localparam int PERSIST_W = 8;
  localparam int CW        = 4;
  localparam int CNT_MOD   = 1 << CW;

  localparam logic [2:0] T_GT = 3'b100;
  localparam logic [2:0] T_EQ = 3'b010;
  localparam logic [2:0] T_LT = 3'b001;

  typedef struct {
    logic        above;
    logic        known;
    logic        rp;
    logic        fp;
    logic [31:0] rc;
    logic [31:0] fc;
    logic [31:0] run;
    logic        err;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 greater;
  logic                 equal;
  logic                 smaller;
  logic                 clear;
  logic                 state_above;
  logic                 state_known;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [CW-1:0]        rise_count;
  logic [CW-1:0]        fall_count;
  logic [PERSIST_W-1:0] run_len;
  logic                 err;

  exp_t  sb[$];
  int    tests_run;
  int    tests_failed;
  string step_tag;

  int m_state;
  int m_run;
  int m_rc;
  int m_fc;
  bit m_err;

  cmp_crossing_detector #(
    .PERSIST       (PERSIST),
    .PERSIST_W     (PERSIST_W),
    .EVT_CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .greater     (greater),
    .equal       (equal),
    .smaller     (smaller),
    .clear       (clear),
    .state_above (state_above),
    .state_known (state_known),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .rise_count  (rise_count),
    .fall_count  (fall_count),
    .run_len     (run_len),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample kinds: 0 = EQ/hold, 1 = GT, 2 = LT, 3 = rejected triplet.
  function automatic int decodeTrip(logic [2:0] t);
`ifdef CMP_ONEHOT_CHECK_EN
    if (t == T_GT) return 1;
    if (t == T_LT) return 2;
    if (t == T_EQ) return 0;
    return 3;
`else
    if (t[2]) return 1;
    if (t[0]) return 2;
    return 0;
`endif
  endfunction

  task automatic checkField(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", step_tag, name, obs, exp_v);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    tests_run++;
    assert (sb.size() > 0) else begin
      tests_failed++;
      $error("[TB] FAIL %s/scoreboard observed=empty expected=entry", step_tag);
      return;
    end
    e = sb.pop_front();
    checkField("state_above", 32'(state_above), 32'(e.above));
    checkField("state_known", 32'(state_known), 32'(e.known));
    checkField("rise_pulse",  32'(rise_pulse),  32'(e.rp));
    checkField("fall_pulse",  32'(fall_pulse),  32'(e.fp));
    checkField("rise_count",  32'(rise_count),  e.rc);
    checkField("fall_count",  32'(fall_count),  e.fc);
    checkField("run_len",     32'(run_len),     e.run);
    checkField("err",         32'(err),         32'(e.err));
    checkField("pulse_excl",  32'(rise_pulse & fall_pulse), 32'd0);
  endtask

  // Drive one cycle, advance the model, queue its prediction, then compare
  // just after the edge that consumes the inputs.
  task automatic applyStimulus(input bit rst, input bit v, input logic [2:0] t, input bit clr);
    exp_t e;
    int   k;
    bit   rp;
    bit   fp;
    rst_n    = ~rst;
    in_valid = v;
    {greater, equal, smaller} = t;
    clear    = clr;
    rp = 1'b0;
    fp = 1'b0;
    if (rst) begin
      m_state = 0; m_run = 0; m_rc = 0; m_fc = 0; m_err = 1'b0;
    end else begin
      if (v) begin
        k = decodeTrip(t);
        if (k == 3) m_err = 1'b1;
        if (m_state == 0) begin
          if (k == 1) m_state = 2;
          else if (k == 2) m_state = 1;
        end else if (m_state == 1) begin
          if (k == 1) begin
            if (m_run + 1 == PERSIST) begin
              m_state = 2; m_run = 0; rp = 1'b1; m_rc = (m_rc + 1) % CNT_MOD;
            end else m_run++;
          end else if (k == 2) m_run = 0;
        end else begin
          if (k == 2) begin
            if (m_run + 1 == PERSIST) begin
              m_state = 1; m_run = 0; fp = 1'b1; m_fc = (m_fc + 1) % CNT_MOD;
            end else m_run++;
          end else if (k == 1) m_run = 0;
        end
      end
      if (clr) begin
        m_rc = 0; m_fc = 0; m_err = 1'b0;
      end
    end
    e.above = (m_state == 2);
    e.known = (m_state != 0);
    e.rp    = rp;
    e.fp    = fp;
    e.rc    = 32'(m_rc);
    e.fc    = 32'(m_fc);
    e.run   = 32'(m_run);
    e.err   = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    {greater, equal, smaller} = 3'b000;
    @(posedge clk);
    #1;

    step_tag = "reset";       applyStimulus(1, 0, T_EQ, 0);
    step_tag = "init_eq";     applyStimulus(0, 1, T_EQ, 0);
    step_tag = "init_gt";     applyStimulus(0, 1, T_GT, 0);
    step_tag = "to_below";    repeat (3) applyStimulus(0, 1, T_LT, 0);
    step_tag = "persist";     repeat (3) applyStimulus(0, 1, T_GT, 0);
    step_tag = "back_below";  repeat (3) applyStimulus(0, 1, T_LT, 0);

    step_tag = "run_break";
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, T_LT, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 0, T_LT, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 0, T_GT, 0);

    step_tag = "eq_hold";
    applyStimulus(0, 1, T_LT, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, T_EQ, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, T_GT, 0);

    step_tag = "wrap";
    for (int i = 0; i < CNT_MOD; i++) begin
      repeat (3) applyStimulus(0, 1, T_LT, 0);
      repeat (3) applyStimulus(0, 1, T_GT, 0);
    end

    step_tag = "clear_rise";
    repeat (3) applyStimulus(0, 1, T_LT, 0);
    repeat (2) applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, T_GT, 1);

    step_tag = "clear_only";
    applyStimulus(0, 1, T_LT, 0);
    applyStimulus(0, 0, T_EQ, 1);

    step_tag = "mid_reset";
    applyStimulus(0, 1, T_LT, 0);
    applyStimulus(1, 1, T_LT, 0);

    step_tag = "bad_triplet";
    applyStimulus(0, 1, T_GT, 0);
    repeat (3) applyStimulus(0, 1, T_LT, 0);
    applyStimulus(0, 1, T_GT, 0);
    applyStimulus(0, 1, 3'b110, 0);
    applyStimulus(0, 1, 3'b000, 0);
    applyStimulus(0, 1, 3'b111, 0);
    applyStimulus(0, 0, T_EQ, 1);

    step_tag = "random";
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
